// File: rtl/move_btn_conditioner_pkg.sv
// Shared constants and FSM encoding for the move-button conditioning path.
// Default counts assume the 25.175 MHz pixel clock.
package move_btn_conditioner_pkg;

  localparam int CLK_HZ              = 25_175_000;
  localparam int DEF_CNT_W           = 24;
  localparam int DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int DEF_REPEAT_DELAY    = 12_500_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } btn_state_t;

endpackage

// File: rtl/move_btn_conditioner_btn_sync.sv
// Two-flop synchroniser for asynchronous pad inputs; both flops clear to 0 on reset.
module btn_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/move_btn_conditioner.sv
// Move-button conditioner: synchroniser, press/release debounce FSM and a
// one-cycle move pulse with optional hold-to-repeat.
module move_btn_conditioner
  import move_btn_conditioner_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_move,
  output logic o_held
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             w_sync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_rep_first;
  logic             r_move;
  logic             r_held;

  btn_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_btn),
    .o_sync  (w_sync)
  );

  // Timer is cleared on every state change and only compared for equality,
  // so it never needs to wrap; it parks in IDLE and in HELD without repeat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_rep_first <= 1'b1;
      r_move      <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_move  <= 1'b0;
      r_timer <= r_timer + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_sync) r_state <= ST_PRESS_DB;
        end
        ST_PRESS_DB: begin
          if (!w_sync) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else if (r_timer == DB_LAST) begin
            r_state     <= ST_HELD;
            r_timer     <= '0;
            r_move      <= 1'b1;
            r_rep_first <= 1'b1;
            r_held      <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_DB;
            r_timer <= '0;
          end else if (REPEAT_EN) begin
            if (r_rep_first && (r_timer == RD_LAST)) begin
              r_move      <= 1'b1;
              r_timer     <= '0;
              r_rep_first <= 1'b0;
            end else if (!r_rep_first && (r_timer == RP_LAST)) begin
              r_move  <= 1'b1;
              r_timer <= '0;
            end
          end else begin
            r_timer <= r_timer;
          end
        end
        ST_RELEASE_DB: begin
          // A bounce back high resumes HELD without firing; rep_first is kept.
          if (w_sync) begin
            r_state <= ST_HELD;
            r_timer <= '0;
          end else if (r_timer == DB_LAST) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_held  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_move = r_move;
  assign o_held = r_held;

endmodule

// File: tb/tb_move_btn_conditioner.sv
// Bench for move_btn_conditioner: two instances (repeat on/off) against a
// cycle-number based behavioural model, plus hand-computed scenario checks.
module tb_move_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_btn = 1'b0;
  logic moveA, heldA, moveB, heldB;

  int compared = 0;
  int mismatched = 0;
  int cycCount = 0;
  int testStart = 0;
  int pulsesA[$];
  int pulsesB[$];
  int expQ[$];
  int heldRiseA = -1, heldFallA = -1, heldCountA = 0;
  bit heldPrevA = 1'b0;
  bit padWave[$];
  bit rstWave[$];

  // Model: index 0 has repeat enabled, index 1 has it disabled.
  bit padDly0, padDly1;
  bit mPressed[2];
  int mStreak[2];
  int mNextFire[2];
  bit mFirstUsed[2];
  bit mMove[2];
  int mEdge = 0;

  move_btn_conditioner #(
    .CNT_W(8), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dutRep (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .o_move(moveA), .o_held(heldA)
  );

  move_btn_conditioner #(
    .CNT_W(8), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dutOne (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .o_move(moveB), .o_held(heldB)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycCount <= cycCount + 1;

  task automatic checkOutput(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycCount - testStart, got, exp);
    end
  endtask

  // A press is accepted once the synchronised level has been high for DB+1
  // consecutive edges, a release likewise; repeats fire at scheduled edge numbers.
  task automatic modelStep(input int c, input bit syncNow);
    bit repeatEn;
    repeatEn = (c == 0);
    mMove[c] = 1'b0;
    if (!mPressed[c]) begin
      mStreak[c] = syncNow ? mStreak[c] + 1 : 0;
      if (mStreak[c] == DB + 1) begin
        mPressed[c] = 1'b1;
        mStreak[c] = 0;
        mMove[c] = 1'b1;
        mFirstUsed[c] = 1'b0;
        mNextFire[c] = mEdge + RD;
      end
    end else if (!syncNow) begin
      mStreak[c]++;
      if (mStreak[c] == DB + 1) begin
        mPressed[c] = 1'b0;
        mStreak[c] = 0;
      end
    end else if (mStreak[c] != 0) begin
      mStreak[c] = 0;
      mNextFire[c] = mEdge + (mFirstUsed[c] ? RP : RD);
    end else if (repeatEn && mEdge == mNextFire[c]) begin
      mMove[c] = 1'b1;
      mFirstUsed[c] = 1'b1;
      mNextFire[c] = mEdge + RP;
    end
  endtask

  always @(posedge i_clk) begin
    bit syncNow;
    mEdge++;
    if (!i_rst_n) begin
      padDly0 = 1'b0;
      padDly1 = 1'b0;
      for (int c = 0; c < 2; c++) begin
        mPressed[c] = 1'b0;
        mStreak[c] = 0;
        mNextFire[c] = 0;
        mFirstUsed[c] = 1'b0;
        mMove[c] = 1'b0;
      end
    end else begin
      syncNow = padDly1;
      padDly1 = padDly0;
      padDly0 = i_btn;
      for (int c = 0; c < 2; c++) modelStep(c, syncNow);
    end
  end

  always @(negedge i_clk) begin
    int rel;
    checkOutput("move_rep", int'(moveA), i_rst_n ? int'(mMove[0]) : 0);
    checkOutput("held_rep", int'(heldA), i_rst_n ? int'(mPressed[0]) : 0);
    checkOutput("move_one", int'(moveB), i_rst_n ? int'(mMove[1]) : 0);
    checkOutput("held_one", int'(heldB), i_rst_n ? int'(mPressed[1]) : 0);
    rel = cycCount - testStart;
    if (moveA) pulsesA.push_back(rel);
    if (moveB) pulsesB.push_back(rel);
    if (heldA && !heldPrevA) heldRiseA = rel;
    if (!heldA && heldPrevA) heldFallA = rel;
    if (heldA) heldCountA++;
    heldPrevA = heldA;
  end

  task automatic makeWave(input int len, input int hiLo, input int hiHi);
    padWave.delete();
    rstWave.delete();
    for (int k = 0; k < len; k++) begin
      padWave.push_back(k >= hiLo && k <= hiHi);
      rstWave.push_back(1'b1);
    end
  endtask

  // Wave entry k is driven just after edge k (cycle 0 = first entry).
  task automatic applyStimulus(input int tail);
    pulsesA.delete();
    pulsesB.delete();
    heldRiseA = -1;
    heldFallA = -1;
    heldCountA = 0;
    @(posedge i_clk);
    #1;
    testStart = cycCount;
    for (int k = 0; k < padWave.size(); k++) begin
      i_btn = padWave[k];
      i_rst_n = rstWave[k];
      @(posedge i_clk);
      #1;
    end
    i_btn = 1'b0;
    i_rst_n = 1'b1;
    repeat (tail) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic checkPulses(input string name, input bit useA);
    int n;
    n = useA ? pulsesA.size() : pulsesB.size();
    checkOutput({name, "_count"}, n, expQ.size());
    for (int i = 0; i < n && i < expQ.size(); i++)
      checkOutput({name, "_at"}, useA ? pulsesA[i] : pulsesB[i], expQ[i]);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit lvl;
    int len;
    bit doRst;

    i_rst_n = 1'b0;
    i_btn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_move", int'(moveA), 0);
    checkOutput("reset_held", int'(heldA), 0);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;

    // Clean press held 15 cycles
    makeWave(15, 0, 14);
    applyStimulus(20);
    expQ = '{7};
    checkPulses("t1_rep", 1'b1);
    checkPulses("t1_one", 1'b0);
    checkOutput("t1_held_rise", heldRiseA, 7);
    checkOutput("t1_held_fall", heldFallA, 22);

    // Short bounce rejected
    makeWave(2, 0, 1);
    applyStimulus(15);
    expQ = {};
    checkPulses("t2_rep", 1'b1);
    checkPulses("t2_one", 1'b0);
    checkOutput("t2_held_cycles", heldCountA, 0);

    // Long hold with repeats
    makeWave(62, 0, 61);
    applyStimulus(20);
    expQ = '{7, 27, 35, 43, 51, 59};
    checkPulses("t3_rep", 1'b1);
    expQ = '{7};
    checkPulses("t3_one", 1'b0);
    checkOutput("t3_held_fall", heldFallA, 69);

    // Release with a one-cycle glitch
    makeWave(19, 0, 14);
    padWave[17] = 1'b1;
    applyStimulus(20);
    expQ = '{7};
    checkPulses("t4_rep", 1'b1);
    checkOutput("t4_held_fall", heldFallA, 25);
    checkOutput("t4_held_cycles", heldCountA, 18);

    // Reset in the middle of a hold
    makeWave(50, 0, 49);
    rstWave[30] = 1'b0;
    rstWave[31] = 1'b0;
    applyStimulus(20);
    expQ = '{7, 27, 39};
    checkPulses("t5_rep", 1'b1);
    expQ = '{7, 39};
    checkPulses("t5_one", 1'b0);
    checkOutput("t5_held_rise", heldRiseA, 39);
    checkOutput("t5_held_fall", heldFallA, 57);

    // Long hold without repeat
    makeWave(100, 0, 99);
    applyStimulus(20);
    expQ = '{7};
    checkPulses("t6_one", 1'b0);
    checkOutput("t6_rep_count", pulsesA.size(), 11);

    // Random bouncy traffic with occasional resets
    padWave.delete();
    rstWave.delete();
    lvl = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      len = $urandom_range(1, 60);
      doRst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < len; k++) begin
        padWave.push_back(lvl);
        rstWave.push_back(!(doRst && k < 2));
      end
      lvl = !lvl;
    end
    applyStimulus(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
